// File: rtl/log_sel_decoder.sv
// log_sel_decoder
//   Works backwards from a stream of observed (a, b, result) triples of the
//   16-function logic unit to the select code(s) that could have produced
//   every triple. A 16-bit candidate mask starts all-ones and is ANDed with
//   the per-sample match vector one cycle after each accepted sample.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   start                 pulse: clear mask/count and begin a new set (any state)
//   s_valid/s_ready       sample handshake; s_last marks the final sample
//   s_a, s_b, s_lout      observed operands and result
//   res_valid/res_ready   result handshake, result held until accepted
//   res_mask              candidate codes consistent with all samples
//   res_sel               lowest set bit of res_mask (0 when mask is zero)
//   res_unique/res_none   exactly one / no candidate left
//   res_count             accepted samples in this set, saturating
//   busy                  COLLECT or EVAL
module log_sel_decoder #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [WIDTH-1:0]   s_a,
  input  logic [WIDTH-1:0]   s_b,
  input  logic [WIDTH-1:0]   s_lout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [15:0]        res_mask,
  output logic [3:0]         res_sel,
  output logic               res_unique,
  output logic               res_none,
  output logic [COUNT_W-1:0] res_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        mask_q, mask_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               stg_vld_q, stg_vld_d;
  logic [WIDTH-1:0]   stg_a_q, stg_b_q, stg_l_q;

  logic               accept;
  logic [15:0]        match_vec;
  logic [WIDTH-1:0]   fn [16];

  assign s_ready = (state_q == COLLECT) && !start;
  assign accept  = s_valid && s_ready;

  // Reference function table evaluated on the staged sample.
  always_comb begin
    fn[0]  = ~stg_a_q;
    fn[1]  = ~(stg_a_q | stg_b_q);
    fn[2]  = ~stg_a_q & stg_b_q;
    fn[3]  = '0;
    fn[4]  = ~(stg_a_q & stg_b_q);
    fn[5]  = ~stg_b_q;
    fn[6]  = stg_a_q ^ stg_b_q;
    fn[7]  = stg_a_q & ~stg_b_q;
    fn[8]  = ~stg_a_q | stg_b_q;
    fn[9]  = ~(stg_a_q ^ stg_b_q);
    fn[10] = stg_b_q;
    fn[11] = stg_a_q & stg_b_q;
    fn[12] = WIDTH'(1);
    fn[13] = stg_a_q | ~stg_b_q;
    fn[14] = stg_a_q | stg_b_q;
    fn[15] = stg_a_q;
    match_vec = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      match_vec[k] = (fn[k] == stg_l_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = stg_vld_q ? (mask_q & match_vec) : mask_q;
    count_d   = (accept && (count_q != '1)) ? count_q + 1'b1 : count_q;
    stg_vld_d = accept;

    case (state_q)
      IDLE:    state_d = IDLE;
      COLLECT: if (accept && s_last) state_d = EVAL;
      EVAL:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // start overrides everything, including a staged sample and a pending result.
    if (start) begin
      state_d   = COLLECT;
      mask_d    = '1;
      count_d   = '0;
      stg_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '1;
      count_q   <= '0;
      stg_vld_q <= 1'b0;
      stg_a_q   <= '0;
      stg_b_q   <= '0;
      stg_l_q   <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      stg_vld_q <= stg_vld_d;
      if (accept) begin
        stg_a_q <= s_a;
        stg_b_q <= s_b;
        stg_l_q <= s_lout;
      end
    end
  end

  // Result decode straight from the registered mask/count.
  logic [4:0] pop;
  always_comb begin
    res_sel = 4'h0;
    pop     = '0;
    for (int unsigned k = 16; k > 0; k--) begin
      if (mask_q[k-1]) res_sel = 4'(k - 1);
    end
    for (int unsigned k = 0; k < 16; k++) begin
      pop = pop + 5'(mask_q[k]);
    end
  end

  assign res_mask   = mask_q;
  assign res_count  = count_q;
  assign res_unique = (pop == 5'd1);
  assign res_none   = (mask_q == 16'h0000);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q == COLLECT) || (state_q == EVAL);

endmodule

// File: tb/tb_log_sel_decoder.sv
module tb_log_sel_decoder;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last, res_ready;
  logic        s_ready, res_valid, res_unique, res_none, busy;
  logic [15:0] s_a, s_b, s_lout, res_mask;
  logic [3:0]  res_sel;
  logic [7:0]  res_count;

  log_sel_decoder #(.WIDTH(16), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_a(s_a), .s_b(s_b), .s_lout(s_lout),
    .res_valid(res_valid), .res_ready(res_ready), .res_mask(res_mask),
    .res_sel(res_sel), .res_unique(res_unique), .res_none(res_none),
    .res_count(res_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  sel;
    logic        uniq;
    logic        none;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] va[$], vb[$], vl[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_fn(input int code, input logic [15:0] a, input logic [15:0] b);
    case (code)
      0:  return ~a;
      1:  return ~a & ~b;
      2:  return b & ~a;
      3:  return 16'h0000;
      4:  return ~a | ~b;
      5:  return ~b;
      6:  return (a & ~b) | (~a & b);
      7:  return a & ~b;
      8:  return ~a | b;
      9:  return (a & b) | (~a & ~b);
      10: return b;
      11: return a & b;
      12: return 16'h0001;
      13: return a | ~b;
      14: return a | b;
      default: return a;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [15:0] m, input int n);
    exp_t e;
    int   ones = 0;
    logic found = 1'b0;
    e.mask = m;
    e.sel  = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        ones++;
        if (!found) begin
          e.sel = 4'(i);
          found = 1'b1;
        end
      end
    end
    e.uniq = (ones == 1);
    e.none = (ones == 0);
    e.cnt  = (n > 255) ? 8'hFF : 8'(n);
    return e;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] l, input logic last);
    int waited = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_lout = l; s_last = last;
    #1;
    while (!s_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!s_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input int hold);
    exp_t e;
    int   w = 0;
    logic [15:0] m0;
    while (!res_valid && w < 20) begin
      tick();
      w++;
    end
    chk("res_timeout", {31'd0, res_valid}, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("res_mask",   res_mask,   e.mask);
    chk("res_sel",    res_sel,    e.sel);
    chk("res_unique", res_unique, e.uniq);
    chk("res_none",   res_none,   e.none);
    chk("res_count",  res_count,  e.cnt);
    m0 = res_mask;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_mask",  res_mask,  m0);
      chk("hold_count", res_count, e.cnt);
      chk("hold_ready", s_ready,   0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_valid", res_valid, 0);
    chk("post_busy",  busy,      0);
  endtask

  // Plays the queued samples as one set. If use_model is 0 the expected mask
  // comes from emask instead of the reference model.
  task automatic play_set(input logic use_model, input logic [15:0] emask, input int hold);
    logic [15:0] m = 16'hFFFF;
    int n = va.size();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++)
        if (ref_fn(k, va[i], vb[i]) != vl[i]) m[k] = 1'b0;
      send(va[i], vb[i], vl[i], i == n - 1);
    end
    s_valid = 1'b0; s_last = 1'b0;
    sb.push_back(make_exp(use_model ? m : emask, n));
    chk("lat_e0", res_valid, 0);
    tick();
    chk("lat_e1", res_valid, 1);
    wait_result(hold);
    va.delete(); vb.delete(); vl.delete();
  endtask

  task automatic add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] l);
    va.push_back(a); vb.push_back(b); vl.push_back(l);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sready"}, s_ready,    0);
    chk({tag, "_rvalid"}, res_valid,  0);
    chk({tag, "_busy"},   busy,       0);
    chk({tag, "_mask"},   res_mask,   16'hFFFF);
    chk({tag, "_sel"},    res_sel,    0);
    chk({tag, "_uniq"},   res_unique, 0);
    chk({tag, "_none"},   res_none,   0);
    chk({tag, "_count"},  res_count,  0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; res_ready = 1'b0;
    s_a = '0; s_b = '0; s_lout = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("rst");

    add(16'h00FF, 16'h0F0F, 16'h0FF0);
    play_set(1'b0, 16'h0040, 0);
    add(16'h0000, 16'h0000, 16'h0000);
    play_set(1'b0, 16'hCCCC, 0);
    add(16'h1234, 16'hABCD, 16'h0001);
    play_set(1'b0, 16'h1000, 0);
    add(16'h1234, 16'hABCD, 16'h0000);
    play_set(1'b0, 16'h0008, 0);
    add(16'h0000, 16'h0000, 16'h0000);
    add(16'hFFFF, 16'hFFFF, 16'h1234);
    play_set(1'b0, 16'h0000, 0);

    // three xor samples, result held off for five cycles
    add(16'h00FF, 16'h0F0F, 16'h0FF0);
    add(16'h1234, 16'h5678, 16'h444C);
    add(16'hFFFF, 16'h0000, 16'hFFFF);
    play_set(1'b0, 16'h0040, 5);

    // start with a sample in the same cycle: not accepted
    s_valid = 1'b1; s_a = 16'h00FF; s_b = 16'h0F0F; s_lout = 16'h0FF0; s_last = 1'b1;
    start = 1'b1;
    #1;
    chk("start_sready", s_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    chk("start_count", res_count, 0);
    chk("start_busy",  busy,      1);
    send(16'h00FF, 16'h0F0F, 16'h0FF0, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    sb.push_back(make_exp(16'h0040, 1));
    wait_result(0);

    // reset in the middle of a set
    pulse_start();
    send(16'h0001, 16'h0002, 16'h0003, 1'b0);
    send(16'h0004, 16'h0008, 16'h000C, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    add(16'h00FF, 16'h0F0F, 16'h0FF0);
    play_set(1'b0, 16'h0040, 0);

    // randomised sets checked against the reference model
    for (int t = 0; t < 8; t++) begin
      int code = int'($urandom_range(15, 0));
      int n    = int'($urandom_range(4, 1));
      for (int i = 0; i < n; i++) begin
        logic [15:0] a = 16'($urandom);
        logic [15:0] b = 16'($urandom);
        add(a, b, ref_fn(code, a, b));
      end
      play_set(1'b1, 16'h0000, 0);
    end

    // count saturation
    for (int i = 0; i < 260; i++) begin
      logic [15:0] a = 16'($urandom);
      add(a, 16'($urandom), a);
    end
    play_set(1'b1, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
